// File: rtl/vyapaar_pkg.sv
// vyapaar_pkg: shared Q8.8 types, constants and valuator FSM state
package vyapaar_pkg;
  localparam int FRAC_BITS = 8;
  localparam logic signed [15:0] Q_ONE = 16'sd256;
  localparam logic signed [15:0] Q_MAX = 16'sd32767;
  typedef logic signed [15:0] q8_8_t;
  typedef enum logic [1:0] {IDLE, STEP, SCALE, DONE} valuator_state_t;
endpackage

// File: rtl/portfolio_valuator_if.sv
// portfolio_valuator_if: returns/weights/valuation bus between producer and valuator
interface portfolio_valuator_if import vyapaar_pkg::*; #(parameter int N_STOCKS = 3);
  logic ret_valid, ret_ready, weights_valid, value_valid;
  q8_8_t [N_STOCKS-1:0] returns, weights;
  logic [15:0] capital;
  logic [31:0] value, peak, drawdown;
  modport master (
    output ret_valid, returns, weights_valid, weights, capital,
    input ret_ready, value_valid, value, peak, drawdown
  );
  modport slave (
    input ret_valid, returns, weights_valid, weights, capital,
    output ret_ready, value_valid, value, peak, drawdown
  );
endinterface

// File: rtl/growth_mac.sv
// growth_mac: clamped growth factor, saturated growth update, g*w product and capital scaling
module growth_mac import vyapaar_pkg::*; (
  input  q8_8_t              g_i,
  input  q8_8_t              r_i,
  input  q8_8_t              w_i,
  input  logic [15:0]        capital_i,
  input  logic signed [39:0] acc_i,
  output q8_8_t              g_o,
  output logic signed [31:0] gw_o,
  output logic signed [55:0] p_o
);
  logic signed [16:0] f_raw, f;
  logic signed [33:0] gf, gs;
  always_comb begin
    f_raw = $signed({r_i[15], r_i}) + 17'sd256;
    f = f_raw < 0 ? '0 : f_raw;
    gf = 34'(g_i) * 34'(f);
    gs = gf >>> FRAC_BITS;
    g_o = gs < 0 ? '0 : gs > Q_MAX ? Q_MAX : gs[15:0];
    gw_o = 32'(g_o) * 32'(w_i);
    p_o = 56'($signed({1'b0, capital_i})) * 56'(acc_i);
  end
endmodule

// File: rtl/portfolio_valuator.sv
// portfolio_valuator: per-stock growth tracking and portfolio valuation; VALUATOR_DRAWDOWN_EN adds peak/drawdown
module portfolio_valuator import vyapaar_pkg::*; #(parameter int N_STOCKS = 3) (
  input logic clk,
  input logic rst_n,
  portfolio_valuator_if.slave pv_if
);
  localparam int KW = $clog2(N_STOCKS);
  valuator_state_t state_q, state_d;
  q8_8_t [N_STOCKS-1:0] g_q, w_q, r_q;
  logic [KW-1:0] k_q;
  logic signed [39:0] acc_q;
  logic [31:0] value_q, v_sat;
  q8_8_t g_new;
  logic signed [31:0] gw;
  logic signed [55:0] p, v;
  logic last;
  assign last = k_q == KW'(N_STOCKS - 1);
  growth_mac u_mac (
    .g_i(g_q[k_q]), .r_i(r_q[k_q]), .w_i(w_q[k_q]),
    .capital_i(pv_if.capital), .acc_i(acc_q),
    .g_o(g_new), .gw_o(gw), .p_o(p)
  );
  always_comb begin
    v = p >>> 16;
    v_sat = v < 0 ? '0 : v > 56'sd4294967295 ? '1 : v[31:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (pv_if.ret_valid ? STEP : IDLE) :
              state_q == STEP  ? (last ? SCALE : STEP) :
              state_q == SCALE ? DONE : IDLE;
  end
  always_comb begin
    pv_if.ret_ready = state_q == IDLE;
    pv_if.value_valid = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q <= {N_STOCKS{Q_ONE}};
      w_q <= '0;
      r_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      value_q <= '0;
    end else begin
      if (pv_if.weights_valid) w_q <= pv_if.weights;
      if (state_q == IDLE && pv_if.ret_valid) begin
        r_q <= pv_if.returns;
        k_q <= '0;
        acc_q <= '0;
      end
      if (state_q == STEP) begin
        g_q[k_q] <= g_new;
        acc_q <= acc_q + 40'(gw);
        k_q <= k_q + KW'(1);
      end
      if (state_q == SCALE) value_q <= v_sat;
    end
  end
  assign pv_if.value = value_q;
`ifdef VALUATOR_DRAWDOWN_EN
  // registered on the SCALE edge so both line up with value_valid in DONE
  logic [31:0] peak_q, peak_d, dd_q, dd_d;
  always_comb begin
    peak_d = v_sat > peak_q ? v_sat : peak_q;
    dd_d = peak_d - v_sat > dd_q ? peak_d - v_sat : dd_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
      dd_q <= '0;
    end else if (state_q == SCALE) begin
      peak_q <= peak_d;
      dd_q <= dd_d;
    end
  end
  assign pv_if.peak = peak_q;
  assign pv_if.drawdown = dd_q;
`else
  assign pv_if.peak = '0;
  assign pv_if.drawdown = '0;
`endif
endmodule

// File: tb/tb_portfolio_valuator.sv
// tb_portfolio_valuator: directed self-checking bench for portfolio_valuator
module tb_portfolio_valuator;
  import vyapaar_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int pass = 0;
  portfolio_valuator_if #(.N_STOCKS(3)) pv_if ();
  portfolio_valuator #(.N_STOCKS(3)) dut (.clk(clk), .rst_n(rst_n), .pv_if(pv_if));
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    pv_if.ret_valid = 1'b0;
    pv_if.weights_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_weights(input q8_8_t w0, input q8_8_t w1, input q8_8_t w2);
    pv_if.weights = {w2, w1, w0};
    pv_if.weights_valid = 1'b1;
    @(posedge clk); #1;
    pv_if.weights_valid = 1'b0;
  endtask

  task automatic run_update(input q8_8_t r0, input q8_8_t r1, input q8_8_t r2,
                            output int lat, output logic [31:0] val);
    int n = 0;
    while (!pv_if.ret_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    pv_if.returns = {r2, r1, r0};
    pv_if.ret_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      pv_if.ret_valid = 1'b0;
      pv_if.weights_valid = 1'b0;
    end while (!pv_if.value_valid && lat < 20);
    val = pv_if.value;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (pv_if.ret_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", pv_if.ret_ready); else pass++;
    total++; if (pv_if.value_valid !== 1'b0) $display("FAIL reset_value_valid got=%0b exp=0", pv_if.value_valid); else pass++;
    total++; if (pv_if.value !== 32'd0) $display("FAIL reset_value got=%0d exp=0", pv_if.value); else pass++;
    total++; if (pv_if.peak !== 32'd0) $display("FAIL reset_peak got=%0d exp=0", pv_if.peak); else pass++;
    total++; if (pv_if.drawdown !== 32'd0) $display("FAIL reset_drawdown got=%0d exp=0", pv_if.drawdown); else pass++;
    total++; if (dut.g_q[0] !== 16'sd256) $display("FAIL reset_g0 got=%0d exp=256", dut.g_q[0]); else pass++;
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] v;
    set_weights(16'sd256, 16'sd0, 16'sd0);
    pv_if.capital = 16'd10000;
    run_update(16'sd26, 16'sd0, 16'sd0, lat, v);
    total++; if (lat !== 5) $display("FAIL basic_latency got=%0d exp=5", lat); else pass++;
    total++; if (v !== 32'd11015) $display("FAIL basic_value got=%0d exp=11015", v); else pass++;
    total++; if (dut.g_q[0] !== 16'sd282) $display("FAIL basic_g0 got=%0d exp=282", dut.g_q[0]); else pass++;
    @(posedge clk); #1;
    total++; if (pv_if.ret_ready !== 1'b1) $display("FAIL basic_ready_back got=%0b exp=1", pv_if.ret_ready); else pass++;
    total++; if (pv_if.value_valid !== 1'b0) $display("FAIL basic_valid_pulse got=%0b exp=0", pv_if.value_valid); else pass++;
    repeat (3) @(posedge clk); #1;
    total++; if (pv_if.value !== 32'd11015) $display("FAIL basic_value_hold got=%0d exp=11015", pv_if.value); else pass++;
  endtask

  task automatic test_wipeout();
    int lat;
    logic [31:0] v;
    run_update(-16'sd256, 16'sd0, 16'sd0, lat, v);
    total++; if (v !== 32'd0) $display("FAIL wipe_value got=%0d exp=0", v); else pass++;
    total++; if (dut.g_q[0] !== 16'sd0) $display("FAIL wipe_g0 got=%0d exp=0", dut.g_q[0]); else pass++;
    run_update(16'sd128, 16'sd0, 16'sd0, lat, v);
    total++; if (v !== 32'd0) $display("FAIL wipe_recover_value got=%0d exp=0", v); else pass++;
    total++; if (dut.g_q[0] !== 16'sd0) $display("FAIL wipe_recover_g0 got=%0d exp=0", dut.g_q[0]); else pass++;
  endtask

  task automatic test_saturate();
    int lat;
    logic [31:0] v;
    int exp_g [7] = '{512, 1024, 2048, 4096, 8192, 16384, 32767};
    int exp_v [7] = '{20000, 40000, 80000, 160000, 320000, 640000, 1279960};
    apply_reset();
    set_weights(16'sd256, 16'sd0, 16'sd0);
    pv_if.capital = 16'd10000;
    for (int i = 0; i < 7; i++) begin
      run_update(16'sd256, 16'sd0, 16'sd0, lat, v);
      total++; if (dut.g_q[0] !== 16'(exp_g[i])) $display("FAIL sat_g0[%0d] got=%0d exp=%0d", i, dut.g_q[0], exp_g[i]); else pass++;
      total++; if (v !== 32'(exp_v[i])) $display("FAIL sat_value[%0d] got=%0d exp=%0d", i, v, exp_v[i]); else pass++;
    end
  endtask

  task automatic test_mix();
    int lat;
    logic [31:0] v;
    apply_reset();
    pv_if.capital = 16'd1000;
    pv_if.weights = {-16'sd32, 16'sd64, 16'sd128};
    pv_if.weights_valid = 1'b1;
    run_update(16'sd0, 16'sd128, -16'sd128, lat, v);
    total++; if (v !== 32'd812) $display("FAIL mix_value got=%0d exp=812", v); else pass++;
    total++; if (dut.g_q[1] !== 16'sd384) $display("FAIL mix_g1 got=%0d exp=384", dut.g_q[1]); else pass++;
    total++; if (dut.g_q[2] !== 16'sd128) $display("FAIL mix_g2 got=%0d exp=128", dut.g_q[2]); else pass++;
    set_weights(-16'sd256, 16'sd0, 16'sd0);
    run_update(16'sd0, 16'sd0, 16'sd0, lat, v);
    total++; if (v !== 32'd0) $display("FAIL mix_negative_clamp got=%0d exp=0", v); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] rdy_mask = '0;
    logic [11:0] vv_mask = '0;
    logic [31:0] vals [2];
    int nv = 0;
    apply_reset();
    set_weights(16'sd256, 16'sd0, 16'sd0);
    pv_if.capital = 16'd10000;
    pv_if.returns = {16'sd0, 16'sd0, 16'sd26};
    pv_if.ret_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rdy_mask[c] = pv_if.ret_ready;
      vv_mask[c] = pv_if.value_valid;
      if (pv_if.value_valid && nv < 2) begin
        vals[nv] = pv_if.value;
        nv++;
      end
      @(posedge clk); #1;
      if (c == 6) pv_if.ret_valid = 1'b0;
    end
    total++; if (rdy_mask !== 12'b0000_0100_0001) $display("FAIL b2b_ready_mask got=%b exp=000001000001", rdy_mask); else pass++;
    total++; if (vv_mask !== 12'b1000_0010_0000) $display("FAIL b2b_valid_mask got=%b exp=100000100000", vv_mask); else pass++;
    total++; if (nv !== 2) $display("FAIL b2b_update_count got=%0d exp=2", nv); else pass++;
    total++; if (vals[0] !== 32'd11015) $display("FAIL b2b_value0 got=%0d exp=11015", vals[0]); else pass++;
    total++; if (vals[1] !== 32'd12109) $display("FAIL b2b_value1 got=%0d exp=12109", vals[1]); else pass++;
    total++; if (dut.g_q[0] !== 16'sd310) $display("FAIL b2b_g0 got=%0d exp=310", dut.g_q[0]); else pass++;
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [31:0] v;
    apply_reset();
    set_weights(16'sd256, 16'sd0, 16'sd0);
    pv_if.capital = 16'd10000;
    run_update(16'sd100, 16'sd0, 16'sd0, lat, v);
    pv_if.returns = {16'sd0, 16'sd0, 16'sd26};
    pv_if.ret_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pv_if.ret_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (pv_if.ret_ready !== 1'b1) $display("FAIL midrst_ready got=%0b exp=1", pv_if.ret_ready); else pass++;
    total++; if (pv_if.value !== 32'd0) $display("FAIL midrst_value got=%0d exp=0", pv_if.value); else pass++;
    total++; if (dut.g_q[0] !== 16'sd256) $display("FAIL midrst_g0 got=%0d exp=256", dut.g_q[0]); else pass++;
    total++; if (dut.w_q[0] !== 16'sd0) $display("FAIL midrst_w0 got=%0d exp=0", dut.w_q[0]); else pass++;
    rst_n = 1'b1;
    set_weights(16'sd256, 16'sd0, 16'sd0);
    run_update(16'sd26, 16'sd0, 16'sd0, lat, v);
    total++; if (v !== 32'd11015) $display("FAIL midrst_fresh_value got=%0d exp=11015", v); else pass++;
    total++; if (lat !== 5) $display("FAIL midrst_latency got=%0d exp=5", lat); else pass++;
  endtask

  task automatic test_drawdown();
    int lat;
    logic [31:0] v;
`ifdef VALUATOR_DRAWDOWN_EN
    logic [31:0] exp_peak = 32'd11015;
    logic [31:0] exp_dd = 32'd2015;
`else
    logic [31:0] exp_peak = 32'd0;
    logic [31:0] exp_dd = 32'd0;
`endif
    apply_reset();
    set_weights(16'sd256, 16'sd0, 16'sd0);
    pv_if.capital = 16'd10000;
    run_update(16'sd26, 16'sd0, 16'sd0, lat, v);
    total++; if (pv_if.peak !== exp_peak) $display("FAIL dd_peak_first got=%0d exp=%0d", pv_if.peak, exp_peak); else pass++;
    total++; if (pv_if.drawdown !== 32'd0) $display("FAIL dd_drawdown_first got=%0d exp=0", pv_if.drawdown); else pass++;
    pv_if.capital = 16'd8171;
    run_update(16'sd0, 16'sd0, 16'sd0, lat, v);
    total++; if (v !== 32'd9000) $display("FAIL dd_value_second got=%0d exp=9000", v); else pass++;
    total++; if (pv_if.peak !== exp_peak) $display("FAIL dd_peak_second got=%0d exp=%0d", pv_if.peak, exp_peak); else pass++;
    total++; if (pv_if.drawdown !== exp_dd) $display("FAIL dd_drawdown_second got=%0d exp=%0d", pv_if.drawdown, exp_dd); else pass++;
  endtask

  initial begin
    pv_if.ret_valid = 1'b0;
    pv_if.weights_valid = 1'b0;
    pv_if.returns = '0;
    pv_if.weights = '0;
    pv_if.capital = '0;
    test_reset();
    test_basic();
    test_wipeout();
    test_saturate();
    test_mix();
    test_back_to_back();
    test_mid_reset();
    test_drawdown();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
